// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS x DATA_WIDTH registers from BASE_ADDR, with byte strobes, SLVERR decode and per-register write pulses.
// Optional AWPROT privilege check on writes enabled by defining AXIL_PROT_CHECK_EN.
module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDRESS_WIDTH:0] ADDR_END =
    {1'b0, BASE_ADDR} + (ADDRESS_WIDTH+1)'(NUM_REGS * BYTES);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                     aw_held, w_held;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q;
  logic [2:0]               aw_prot_q;
  logic [DATA_WIDTH-1:0]    w_data_q;
  logic [BYTES-1:0]         w_strb_q;

  logic                     aw_hs, w_hs, commit;
  logic [ADDRESS_WIDTH-1:0] wr_addr, wr_off;
  logic [2:0]               wr_prot;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [BYTES-1:0]         wr_strb;
  logic [IDX_W-1:0]         wr_idx;
  logic                     wr_in_range, wr_ok;

  logic                     ar_hs;
  logic [ADDRESS_WIDTH-1:0] rd_off;
  logic [IDX_W-1:0]         rd_idx;
  logic                     rd_in_range;

  assign AWREADY = !aw_held && !BVALID;
  assign WREADY  = !w_held && !BVALID;
  assign ARREADY = !RVALID;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  // A write commits on the edge where each half is either already held or handshaking now.
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_addr = aw_held ? aw_addr_q : AWADDR;
  assign wr_prot = aw_held ? aw_prot_q : AWPROT;
  assign wr_data = w_held ? w_data_q : WDATA;
  assign wr_strb = w_held ? w_strb_q : WSTRB;

  assign wr_off      = wr_addr - BASE_ADDR;
  assign wr_idx      = wr_off[ADDR_LSB +: IDX_W];
  assign wr_in_range = (wr_addr >= BASE_ADDR) && ({1'b0, wr_addr} < ADDR_END);

`ifdef AXIL_PROT_CHECK_EN
  assign wr_ok = wr_in_range && wr_prot[0];
`else
  assign wr_ok = wr_in_range;
`endif

  assign ar_hs       = ARVALID && ARREADY;
  assign rd_off      = ARADDR - BASE_ADDR;
  assign rd_idx      = rd_off[ADDR_LSB +: IDX_W];
  assign rd_in_range = (ARADDR >= BASE_ADDR) && ({1'b0, ARADDR} < ADDR_END);

  // Protection bits and the discarded byte-offset bits are intentionally dropped.
  logic unused;
  assign unused = ^{ARPROT, wr_prot, wr_off, rd_off};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
        aw_prot_q <= AWPROT;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      BVALID <= 1'b0;
      BRESP  <= RESP_OKAY;
    end else if (commit) begin
      BVALID <= 1'b1;
      BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (BVALID && BREADY) begin
      BVALID <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_ok && (wr_idx == IDX_W'(i))) begin
          reg_wr_pulse[i] <= 1'b1;
          for (int b = 0; b < BYTES; b++) begin
            if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Reads sample regs before this edge's write lands, so a same-edge read sees the old value.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      RVALID <= 1'b1;
      RDATA  <= rd_in_range ? regs[rd_idx] : '0;
      RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave (32-bit data, 16 registers at base 0x100).
module tb_axi_lite_reg_slave;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam logic [31:0] BASE = 32'h100;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0] AWPROT, ARPROT;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0] reg_wr_pulse;

  int vectors = 0;
  int errors = 0;
  logic [31:0] exp_regs [NR];

  always #5 ACLK = ~ACLK;

  axi_lite_reg_slave #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  function automatic logic [NR*DW-1:0] exp_q();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_regs[i];
    return v;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] prot, output logic bv, output logic [1:0] br);
    @(negedge ACLK);
    AWADDR = addr; AWPROT = prot; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1; BREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    bv = BVALID; br = BRESP;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic rv, output logic [31:0] rd, output logic [1:0] rr);
    @(negedge ACLK);
    ARADDR = addr; ARPROT = 3'b000; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    rv = RVALID; rd = RDATA; rr = RRESP;
    ARVALID = 1'b0; RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    repeat (2) @(negedge ACLK);
    vectors++; if (reg_q !== exp_q() || reg_wr_pulse !== '0) begin errors++; $display("FAIL reset_regs reg_q=%h pulse=%h", reg_q, reg_wr_pulse); end
    vectors++; if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0 || RDATA !== '0) begin errors++; $display("FAIL reset_resp bv=%b rv=%b br=%b rr=%b rd=%h need zeros", BVALID, RVALID, BRESP, RRESP, RDATA); end
    vectors++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin errors++; $display("FAIL reset_ready aw/w/ar=%b need 111", {AWREADY, WREADY, ARREADY}); end
    ARESETn = 1'b1;
  endtask

  task automatic test_same_cycle();
    logic rv; logic [31:0] rd; logic [1:0] rr;
    @(negedge ACLK);
    AWADDR = BASE + 32'h8; AWPROT = 3'b001; AWVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    exp_regs[2] = 32'hDEADBEEF;
    vectors++; if (reg_q !== exp_q()) begin errors++; $display("FAIL same_cycle_reg reg2=%h need deadbeef", reg_q[2*DW +: DW]); end
    vectors++; if (reg_wr_pulse !== 16'h0004) begin errors++; $display("FAIL same_cycle_pulse got=%h need 0004", reg_wr_pulse); end
    vectors++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin errors++; $display("FAIL same_cycle_b bv=%b br=%b need 1/00", BVALID, BRESP); end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 0;
    vectors++; if (reg_wr_pulse !== '0 || BVALID !== 1'b0) begin errors++; $display("FAIL same_cycle_clear pulse=%h bv=%b need 0/0", reg_wr_pulse, BVALID); end
    axi_read(BASE + 32'h8, rv, rd, rr);
    vectors++; if (rv !== 1'b1 || rd !== 32'hDEADBEEF || rr !== 2'b00) begin errors++; $display("FAIL same_cycle_read rv=%b rd=%h rr=%b need 1/deadbeef/00", rv, rd, rr); end
  endtask

  task automatic test_w_before_aw();
    logic bv; logic [1:0] br;
    axi_write(BASE, 32'hAABBCCDD, 4'hF, 3'b001, bv, br);
    exp_regs[0] = 32'hAABBCCDD;
    vectors++; if (bv !== 1'b1 || br !== 2'b00 || reg_q !== exp_q()) begin errors++; $display("FAIL preload bv=%b br=%b reg0=%h", bv, br, reg_q[DW-1:0]); end
    @(negedge ACLK);
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    WVALID = 0; WDATA = '0; WSTRB = '0;
    vectors++; if (WREADY !== 1'b0 || BVALID !== 1'b0 || reg_q !== exp_q()) begin errors++; $display("FAIL w_held wready=%b bv=%b reg0=%h need 0/0/aabbccdd", WREADY, BVALID, reg_q[DW-1:0]); end
    repeat (2) @(negedge ACLK);
    AWADDR = BASE; AWPROT = 3'b001; AWVALID = 1;
    vectors++; if (AWREADY !== 1'b1) begin errors++; $display("FAIL w_first_awready got=%b need 1", AWREADY); end
    @(posedge ACLK); @(negedge ACLK);
    exp_regs[0] = 32'hAA22CC44;
    vectors++; if (reg_q !== exp_q() || reg_wr_pulse !== 16'h0001 || BVALID !== 1'b1) begin errors++; $display("FAIL w_first_commit reg0=%h pulse=%h bv=%b need aa22cc44/0001/1", reg_q[DW-1:0], reg_wr_pulse, BVALID); end
    AWVALID = 0; BREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic test_bresp_hold();
    @(negedge ACLK);
    AWADDR = BASE + 32'hC; AWVALID = 1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    exp_regs[3] = 32'h12345678;
    AWADDR = BASE + 32'h10; WDATA = 32'hCAFE0000;
    for (int c = 0; c < 5; c++) begin
      vectors++; if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b1_00_00) begin errors++; $display("FAIL bhold_c%0d bv=%b br=%b awr=%b wr=%b need 1/00/0/0", c, BVALID, BRESP, AWREADY, WREADY); end
      @(posedge ACLK); @(negedge ACLK);
    end
    vectors++; if (reg_q !== exp_q()) begin errors++; $display("FAIL bhold_regs reg4=%h need 0", reg_q[4*DW +: DW]); end
    BREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 0;
    vectors++; if (BVALID !== 1'b0 || AWREADY !== 1'b1 || reg_q !== exp_q()) begin errors++; $display("FAIL bhold_release bv=%b awr=%b reg4=%h need 0/1/0", BVALID, AWREADY, reg_q[4*DW +: DW]); end
    @(posedge ACLK); @(negedge ACLK);
    exp_regs[4] = 32'hCAFE0000;
    vectors++; if (BVALID !== 1'b1 || reg_q !== exp_q() || reg_wr_pulse !== 16'h0010) begin errors++; $display("FAIL bhold_second bv=%b reg4=%h pulse=%h need 1/cafe0000/0010", BVALID, reg_q[4*DW +: DW], reg_wr_pulse); end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic test_out_of_range();
    logic bv, rv; logic [1:0] br, rr; logic [31:0] rd;
    @(negedge ACLK);
    AWADDR = BASE + NR*4; AWVALID = 1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    vectors++; if (BVALID !== 1'b1 || BRESP !== 2'b10 || reg_wr_pulse !== '0 || reg_q !== exp_q()) begin errors++; $display("FAIL oor_high_write br=%b pulse=%h need 10/0000 regs unchanged", BRESP, reg_wr_pulse); end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 0;
    axi_write(BASE - 32'h4, 32'h01010101, 4'hF, 3'b001, bv, br);
    vectors++; if (br !== 2'b10 || reg_q !== exp_q()) begin errors++; $display("FAIL oor_low_write br=%b need 10", br); end
    axi_read(BASE + NR*4, rv, rd, rr);
    vectors++; if (rv !== 1'b1 || rd !== 32'h0 || rr !== 2'b10) begin errors++; $display("FAIL oor_read rv=%b rd=%h rr=%b need 1/0/10", rv, rd, rr); end
    axi_write(BASE + NR*4 - 2, 32'h0F0F0F0F, 4'hF, 3'b001, bv, br);
    exp_regs[NR-1] = 32'h0F0F0F0F;
    vectors++; if (br !== 2'b00 || reg_q !== exp_q()) begin errors++; $display("FAIL last_reg_write br=%b reg15=%h need 00/0f0f0f0f", br, reg_q[(NR-1)*DW +: DW]); end
    axi_read(BASE + NR*4 - 4, rv, rd, rr);
    vectors++; if (rd !== 32'h0F0F0F0F || rr !== 2'b00) begin errors++; $display("FAIL last_reg_read rd=%h rr=%b need 0f0f0f0f/00", rd, rr); end
  endtask

  task automatic test_back_to_back();
    @(negedge ACLK);
    ARADDR = BASE + 32'h8; ARVALID = 1;
    AWADDR = BASE + 32'h8; AWVALID = 1; WDATA = 32'h55555555; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    exp_regs[2] = 32'h55555555;
    vectors++; if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_same_edge rd=%h need deadbeef", RDATA); end
    vectors++; if (reg_q !== exp_q() || ARREADY !== 1'b0) begin errors++; $display("FAIL rw_same_edge_reg reg2=%h arready=%b need 55555555/0", reg_q[2*DW +: DW], ARREADY); end
    ARADDR = BASE; AWVALID = 0; WVALID = 0; BREADY = 1; RREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 0;
    vectors++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin errors++; $display("FAIL b2b_gap rv=%b arready=%b need 0/1", RVALID, ARREADY); end
    @(posedge ACLK); @(negedge ACLK);
    vectors++; if (RVALID !== 1'b1 || RDATA !== 32'hAA22CC44) begin errors++; $display("FAIL b2b_second rv=%b rd=%h need 1/aa22cc44", RVALID, RDATA); end
    ARVALID = 0;
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 0;
    AWADDR = BASE + 32'h14; AWVALID = 1; WDATA = 32'hFFFFFFFF; WSTRB = 4'h0; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    vectors++; if (reg_wr_pulse !== 16'h0020 || reg_q !== exp_q() || BRESP !== 2'b00) begin errors++; $display("FAIL zero_strb pulse=%h reg5=%h br=%b need 0020/0/00", reg_wr_pulse, reg_q[5*DW +: DW], BRESP); end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic test_prot();
    logic bv, rv; logic [1:0] br, rr; logic [31:0] rd;
    axi_write(BASE + 32'h4, 32'h00000077, 4'hF, 3'b000, bv, br);
`ifdef AXIL_PROT_CHECK_EN
    vectors++; if (br !== 2'b10 || reg_q !== exp_q()) begin errors++; $display("FAIL prot_unpriv br=%b reg1=%h need 10/0", br, reg_q[DW +: DW]); end
`else
    exp_regs[1] = 32'h00000077;
    vectors++; if (br !== 2'b00 || reg_q !== exp_q()) begin errors++; $display("FAIL prot_ignored br=%b reg1=%h need 00/77", br, reg_q[DW +: DW]); end
`endif
    axi_write(BASE + 32'h4, 32'h00000088, 4'hF, 3'b001, bv, br);
    exp_regs[1] = 32'h00000088;
    vectors++; if (br !== 2'b00 || reg_q !== exp_q()) begin errors++; $display("FAIL prot_priv br=%b reg1=%h need 00/88", br, reg_q[DW +: DW]); end
    axi_read(BASE + 32'h4, rv, rd, rr);
    vectors++; if (rd !== 32'h00000088 || rr !== 2'b00) begin errors++; $display("FAIL prot_read rd=%h rr=%b need 88/00", rd, rr); end
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    WVALID = 0; ARESETn = 0;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    #1;
    vectors++; if (reg_q !== exp_q() || BVALID !== 1'b0 || RVALID !== 1'b0 || WREADY !== 1'b1) begin errors++; $display("FAIL mid_reset bv=%b rv=%b wready=%b need 0/0/1 regs zero", BVALID, RVALID, WREADY); end
    @(negedge ACLK);
    ARESETn = 1;
    AWADDR = BASE + 32'h4; AWPROT = 3'b001; AWVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 0;
    vectors++; if (BVALID !== 1'b0 || reg_wr_pulse !== '0 || reg_q !== exp_q()) begin errors++; $display("FAIL aw_alone bv=%b pulse=%h need 0/0000", BVALID, reg_wr_pulse); end
    WDATA = 32'h00000099; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    exp_regs[1] = 32'h00000099;
    vectors++; if (BVALID !== 1'b1 || reg_q !== exp_q() || reg_wr_pulse !== 16'h0002) begin errors++; $display("FAIL post_reset_commit bv=%b reg1=%h pulse=%h need 1/99/0002", BVALID, reg_q[DW +: DW], reg_wr_pulse); end
    WVALID = 0; BREADY = 1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 0;
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_bresp_hold();
    test_out_of_range();
    test_back_to_back();
    test_prot();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
